ft245_tx_arbiter: RTL

FT245_TX_ARBITER -- requirements
Module: ft245_tx_arbiter

---
 rtl/ft245_tx_arbiter.sv | 119 +++++++++++
 1 files changed

// File: rtl/ft245_tx_arbiter.sv
// ft245_tx_arbiter: round-robin packetiser of two byte channels onto an FT245 TX stream.
// Each packet is framed as header, payload, trailer; timeout or oversize truncates with an abort trailer.
module ft245_tx_arbiter #(
    parameter logic [7:0] CH0_ID      = 8'hA0,
    parameter logic [7:0] CH1_ID      = 8'hA1,
    parameter logic [7:0] END_OK      = 8'h55,
    parameter logic [7:0] END_ABORT   = 8'hAA,
    parameter int         TIMEOUT     = 256,
    parameter int         MAX_PAYLOAD = 512
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] s0_data,
    input  logic       s0_valid,
    input  logic       s0_last,
    output logic       s0_ready,
    input  logic [7:0] s1_data,
    input  logic       s1_valid,
    input  logic       s1_last,
    output logic       s1_ready,
    output logic [7:0] tx_data_si,
    output logic       tx_valid_si,
    input  logic       tx_ready_si,
    output logic [1:0] grant,
    output logic       busy,
    output logic       abort_pulse
);
    typedef enum logic [1:0] {IDLE, PAYLOAD, TRAIL} state_t;

    state_t      state, state_d;
    logic [7:0]  tx_data_d;
    logic        tx_valid_d, abort, abort_d, abort_pulse_d, last1, last1_d;
    logic [1:0]  grant_d;
    logic [15:0] timer, timer_d, count, count_d;
    logic        free, pick1, gv, gl;
    logic [7:0]  gd;

    assign free     = !tx_valid_si || tx_ready_si;
    assign gv       = (grant[0] && s0_valid) || (grant[1] && s1_valid);
    assign gl       = grant[1] ? s1_last : s0_last;
    assign gd       = grant[1] ? s1_data : s0_data;
    // ch1 wins only when alone or when ch0 was served last
    assign pick1    = s1_valid && (!s0_valid || !last1);
    assign s0_ready = state == PAYLOAD && grant[0] && free;
    assign s1_ready = state == PAYLOAD && grant[1] && free;
    assign busy     = state != IDLE;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            tx_data_si  <= 8'h00;
            tx_valid_si <= 1'b0;
            grant       <= 2'b00;
            abort       <= 1'b0;
            abort_pulse <= 1'b0;
            last1       <= 1'b1;
            timer       <= 16'd0;
            count       <= 16'd0;
        end else begin
            state       <= state_d;
            tx_data_si  <= tx_data_d;
            tx_valid_si <= tx_valid_d;
            grant       <= grant_d;
            abort       <= abort_d;
            abort_pulse <= abort_pulse_d;
            last1       <= last1_d;
            timer       <= timer_d;
            count       <= count_d;
        end
    end

    always_comb begin
        state_d       = state;
        tx_data_d     = tx_data_si;
        tx_valid_d    = tx_valid_si && !tx_ready_si;
        grant_d       = grant;
        abort_d       = abort;
        abort_pulse_d = 1'b0;
        last1_d       = last1;
        timer_d       = timer;
        count_d       = count;
        case (state)
            IDLE: if (free && (s0_valid || s1_valid)) begin
                state_d    = PAYLOAD;
                grant_d    = pick1 ? 2'b10 : 2'b01;
                tx_data_d  = pick1 ? CH1_ID : CH0_ID;
                tx_valid_d = 1'b1;
                timer_d    = 16'd0;
                count_d    = 16'd0;
                abort_d    = 1'b0;
            end
            PAYLOAD: if (free && gv) begin
                tx_data_d  = gd;
                tx_valid_d = 1'b1;
                timer_d    = 16'd0;
                count_d    = count + 16'd1;
                if (gl || count == 16'(MAX_PAYLOAD - 1)) begin
                    state_d = TRAIL;
                    abort_d = !gl;
                end
            end else if (free) begin
                timer_d = timer + 16'd1;
                if (timer == 16'(TIMEOUT - 1)) begin
                    state_d = TRAIL;
                    abort_d = 1'b1;
                end
            end
            TRAIL: if (free) begin
                tx_data_d     = abort ? END_ABORT : END_OK;
                tx_valid_d    = 1'b1;
                last1_d       = grant[1];
                grant_d       = 2'b00;
                abort_pulse_d = abort;
                state_d       = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
endmodule
